uart_tx_buffered: RTL and testbench

//   Buffered UART transmitter driving the cpu_top uart_tx pin. Consumes byte

---
 rtl/uart_tx_buffered.sv | 149 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: CPU byte writes are queued in a FIFO and
// serialised LSB-first on a registered, idle-high serial line.
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       uart_tx
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = PtrW + 1;
  localparam int unsigned BaudW      = $clog2(ClksPerBit);
  localparam logic [BaudW-1:0] BaudMax  = BaudW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]  DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d, busy_q, busy_d, tx_q, tx_d;
  logic              wr_acc, pop, baud_end;
  logic [7:0]        mem_q [FIFO_DEPTH];

  always_comb begin
    // Writes while full are dropped even if a pop frees a slot this cycle.
    wr_acc   = wr_en && !full_q;
    pop      = 1'b0;
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    baud_end = (baud_q == BaudMax);

    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (baud_end) begin
          state_d = StData;
          bit_d   = '0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) shift_d = mem_q[rd_ptr_q];

    count_d = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    full_d   = (count_d == DepthCnt);
    busy_d   = (count_d != '0) || (state_d != StIdle);

    // Line follows the current state, so it trails the FSM by one cycle.
    case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full    = full_q;
  assign busy    = busy_q;
  assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: accepted bytes are queued by the
// stimulus and a line decoder pops and compares each received frame.
module tb_uart_tx_buffered;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       uart_tx;

  int         checks;
  int         failures;
  int         cyc;
  logic [7:0] exp_q[$];
  int         starts[$];

  uart_tx_buffered #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .full   (full),
    .busy   (busy),
    .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns at the negedge after the sampling edge; cyc then names that edge.
  task automatic wr(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_contig(input int nframes);
    check("frame_count", 32'(starts.size()), 32'(nframes));
    for (int i = 1; i < starts.size(); i++) begin
      check("frame_gap", 32'(starts[i] - starts[i-1]), 32'd100);
    end
    starts.delete();
  endtask

  // Line decoder: frame cycle 0 is the first low cycle; sample mid-bit.
  initial begin : monitor
    logic [7:0] rx;
    bit         aborted;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && uart_tx === 1'b0) begin
        t0      = cyc;
        rx      = '0;
        aborted = 1'b0;
        for (int k = 1; k < 100 && !aborted; k++) begin
          @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1'b1;
          end else begin
            if (k == 5) check("start_bit", 32'(uart_tx), 32'd0);
            if (k >= 15 && k <= 85 && (k % 10) == 5) rx[3'((k - 15) / 10)] = uart_tx;
            if (k == 95) check("stop_bit", 32'(uart_tx), 32'd1);
          end
        end
        if (!aborted) begin
          starts.push_back(t0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got %0h expected none", rx);
          end else begin
            check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0;
    int bad;
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || full !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_200", 32'(bad), 32'd0);

    // Single byte latency and frame length
    wr(8'h55, 1'b1);
    n0 = cyc;
    check("lat_n", 32'(uart_tx), 32'd1);
    @(negedge clk);
    check("lat_n1_tx", 32'(uart_tx), 32'd1);
    check("lat_n1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_n2_fall", 32'(uart_tx), 32'd0);
    while (cyc < n0 + 100) @(negedge clk);
    check("busy_end_frame", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    wait_idle(50);
    check_contig(1);

    // Burst into a busy transmitter: fill, then one dropped write
    wr(8'h99, 1'b1);
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    check("fill1_full", 32'(full), 32'd0);
    wr_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk);
    check("fill2_full", 32'(full), 32'd0);
    wr_data = 8'hFF; exp_q.push_back(8'hFF);
    @(negedge clk);
    check("fill3_full", 32'(full), 32'd0);
    wr_data = 8'h00; exp_q.push_back(8'h00);
    @(negedge clk);
    check("fill4_full", 32'(full), 32'd1);
    wr_data = 8'h12;
    @(negedge clk);
    check("drop_full", 32'(full), 32'd1);
    wr_en = 1'b0;
    wait_idle(700);
    check_contig(5);

    // Write dropped on the same edge as a pop, next write accepted
    wr(8'hC7, 1'b1);
    n0 = cyc;
    wr_en = 1'b1;
    foreach (exp_q[i]) begin end
    wr_data = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk);
    wr_data = 8'h22; exp_q.push_back(8'h22);
    @(negedge clk);
    wr_data = 8'h33; exp_q.push_back(8'h33);
    @(negedge clk);
    wr_data = 8'h44; exp_q.push_back(8'h44);
    @(negedge clk);
    wr_en = 1'b0;
    while (cyc < n0 + 100) @(negedge clk);
    check("pre_pop_full", 32'(full), 32'd1);
    wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    check("pop_drop_full", 32'(full), 32'd0);
    wr_data = 8'h66; exp_q.push_back(8'h66);
    @(negedge clk);
    wr_en = 1'b0;
    check("refill_full", 32'(full), 32'd1);
    wait_idle(800);
    check_contig(6);

    // Reset mid-frame
    wr(8'h81, 1'b1);
    n0 = cyc;
    while (cyc < n0 + 47) @(negedge clk);
    check("mid_frame_low", 32'(uart_tx), 32'd0);
    check("mid_frame_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_tx", 32'(uart_tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_full", 32'(full), 32'd0);
    exp_q.delete();
    starts.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_idle", 32'(bad), 32'd0);
    check("post_rst_frames", 32'(starts.size()), 32'd0);

    // Write landing during the stop bit chains with no idle gap
    wr(8'hC3, 1'b1);
    n0 = cyc;
    while (cyc < n0 + 99) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h0F; exp_q.push_back(8'h0F);
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("chain_busy", 32'(busy), 32'd1);
    wait_idle(300);
    check_contig(2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
